// File: rtl/instr_pkg.sv
// Shared definitions for the run-time loadable instruction memory:
// default widths, well-known instruction words and the loader state encoding.
package instr_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 5;

   localparam logic [DEF_DATA_W-1:0] DEF_NOP_WORD = '0;
   localparam logic [DEF_DATA_W-1:0] HALT_WORD    = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/instr_ram_1r1w.sv
// DEPTH x DATA_W storage with one synchronous write port and one synchronous read port.
// Written in the plain inferable form so a vendor RAM macro can replace it.
module instr_ram_1r1w #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Read data only changes on a read, so it holds between fetches.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a streaming auto-increment load port and a one-cycle
// registered fetch port; words never loaded read back as NOP_WORD and are flagged.
module instr_mem_loader
   import instr_pkg::*;
#(
   parameter int                 DATA_W   = DEF_DATA_W,
   parameter int                 ADDR_W   = DEF_ADDR_W,
   parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_err,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              instr_unloaded,
   output logic              busy,
   output state_t            state_dbg
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Handshakes: a load word transfers on a rising edge where load_valid and
   // load_ready are both high; a fetch transfers where fetch_req and fetch_ready
   // are both high, and its result appears with instr_valid on the next cycle.

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q;
   logic [DEPTH-1:0]    vbit_q;
   logic                load_err_q;
   logic                instr_valid_q;
   logic                unloaded_q;
   logic                loaded_q;
   logic [DATA_W-1:0]   rdata;

   logic                wr_en;
   logic                fetch_acc;
   logic                start_go;
   logic                at_end;

   always_comb begin
      state_d     = state_q;
      load_ready  = 1'b0;
      busy        = 1'b0;
      fetch_ready = 1'b0;
      start_go    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               start_go = 1'b1;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            load_ready = 1'b1;
            busy       = 1'b1;
            if (load_valid && (load_last || at_end)) state_d = RUN;
         end
         RUN: begin
            fetch_ready = ~load_start;
            if (load_start) begin
               start_go = 1'b1;
               state_d  = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_en     = load_ready & load_valid;
   assign fetch_acc = fetch_req & fetch_ready;
   assign at_end    = (ptr_q == {ADDR_W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The pointer parks on the last word when a load overruns instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         vbit_q     <= '0;
         load_err_q <= 1'b0;
      end else begin
         if (start_go) begin
            ptr_q      <= load_base;
            load_err_q <= 1'b0;
         end else if (wr_en) begin
            vbit_q[ptr_q] <= 1'b1;
            if (!at_end) ptr_q <= ptr_q + 1'b1;
            else if (!load_last) load_err_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_valid_q <= 1'b0;
         unloaded_q    <= 1'b0;
         loaded_q      <= 1'b0;
      end else begin
         instr_valid_q <= fetch_acc;
         if (fetch_acc) begin
            loaded_q   <= vbit_q[fetch_addr];
            unloaded_q <= ~vbit_q[fetch_addr];
         end
      end
   end

   instr_ram_1r1w #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (ptr_q),
      .wdata (load_data),
      .re    (fetch_acc),
      .raddr (fetch_addr),
      .rdata (rdata)
   );

   // The RAM output is not reset, so loaded_q masks it to NOP after reset.
   assign instr          = loaded_q ? rdata : NOP_WORD;
   assign instr_valid    = instr_valid_q;
   assign instr_unloaded = unloaded_q;
   assign load_err       = load_err_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: scenario tasks driven in sequence,
// fetch results checked against a queue of expected words built from a memory model.
module tb_instr_mem_loader;
   import instr_pkg::*;

   localparam int DW = 8;
   localparam int AW = 5;
   localparam int DEPTH = 2 ** AW;

   logic          clk;
   logic          rst_n;
   logic          load_start;
   logic [AW-1:0] load_base;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_last;
   logic          load_ready;
   logic          load_err;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_ready;
   logic [DW-1:0] instr;
   logic          instr_valid;
   logic          instr_unloaded;
   logic          busy;
   state_t        state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   // Bench-side model of the memory and the loader.
   logic [DW-1:0] model_mem [DEPTH];
   logic          model_vld [DEPTH];
   logic          m_in_load;
   logic [AW-1:0] m_ptr;
   logic          m_err;

   logic [DW:0]   exp_q [$];

   instr_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .NOP_WORD(8'h00)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_start     (load_start),
      .load_base      (load_base),
      .load_valid     (load_valid),
      .load_data      (load_data),
      .load_last      (load_last),
      .load_ready     (load_ready),
      .load_err       (load_err),
      .fetch_req      (fetch_req),
      .fetch_addr     (fetch_addr),
      .fetch_ready    (fetch_ready),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .instr_unloaded (instr_unloaded),
      .busy           (busy),
      .state_dbg      (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;
      m_in_load = 1'b0;
      m_ptr     = '0;
      m_err     = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // driver tasks
   task automatic start_load(input logic [AW-1:0] base);
      @(negedge clk);
      load_start = 1'b1;
      load_base  = base;
      @(negedge clk);
      load_start = 1'b0;
      m_in_load  = 1'b1;
      m_ptr      = base;
      m_err      = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_busy: busy=%b expected 1", busy);
      end
   endtask

   task automatic feed_words(input logic [DW-1:0] w [8], input int n, input logic last_on_final);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         load_valid = 1'b1;
         load_data  = w[i];
         load_last  = last_on_final && (i == n - 1);
         #1;
         n_checks++;
         if (load_ready !== m_in_load) begin
            n_fail++;
            $display("FAIL load_ready word %0d: got %b expected %b", i, load_ready, m_in_load);
         end
         if (m_in_load) begin
            model_mem[m_ptr] = w[i];
            model_vld[m_ptr] = 1'b1;
            if (load_last) m_in_load = 1'b0;
            else if (m_ptr == AW'(DEPTH - 1)) begin
               m_in_load = 1'b0;
               m_err     = 1'b1;
            end else m_ptr = m_ptr + 1'b1;
         end
      end
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      n_checks++;
      if (load_err !== m_err) begin
         n_fail++;
         $display("FAIL load_err: got %b expected %b", load_err, m_err);
      end
      n_checks++;
      if (state_dbg !== (m_in_load ? LOAD : RUN)) begin
         n_fail++;
         $display("FAIL load_state: got %0d expected %0d", state_dbg, m_in_load ? LOAD : RUN);
      end
   endtask

   // Back-to-back fetches; each result is popped and compared one cycle later.
   task automatic run_fetches(input logic [AW-1:0] a [8], input int n);
      logic [DW:0] exp;
      logic [DW:0] last_exp;
      last_exp = '0;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            if (instr_valid !== 1'b1 || exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL fetch_valid %0d: instr_valid=%b queued=%0d", i - 1, instr_valid, exp_q.size());
            end else begin
               exp = exp_q.pop_front();
               last_exp = exp;
               n_checks++;
               if ({instr_unloaded, instr} !== exp) begin
                  n_fail++;
                  $display("FAIL fetch_data %0d: got unl=%b instr=%h expected unl=%b instr=%h",
                           i - 1, instr_unloaded, instr, exp[DW], exp[DW-1:0]);
               end
            end
         end
         if (i < n) begin
            fetch_req  = 1'b1;
            fetch_addr = a[i];
            #1;
            n_checks++;
            if (fetch_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL fetch_ready %0d: got %b expected 1", i, fetch_ready);
            end
            exp_q.push_back(model_vld[a[i]] ? {1'b0, model_mem[a[i]]} : {1'b1, 8'h00});
         end else begin
            fetch_req = 1'b0;
         end
      end
      @(negedge clk);
      n_checks++;
      if (instr_valid !== 1'b0 || {instr_unloaded, instr} !== last_exp) begin
         n_fail++;
         $display("FAIL fetch_hold: valid=%b instr=%h expected valid=0 instr=%h",
                  instr_valid, instr, last_exp[DW-1:0]);
      end
      exp_q.delete();
   endtask

   // scenarios
   task automatic test_reset();
      n_checks++;
      if (instr !== 8'h00 || instr_valid !== 1'b0 || instr_unloaded !== 1'b0 || load_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: instr=%h valid=%b unl=%b err=%b expected 00 0 0 0",
                  instr, instr_valid, instr_unloaded, load_err);
      end
      n_checks++;
      if (state_dbg !== IDLE || busy !== 1'b0 || load_ready !== 1'b0 || fetch_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: state=%0d busy=%b lr=%b fr=%b expected IDLE 0 0 0",
                  state_dbg, busy, load_ready, fetch_ready);
      end
   endtask

   task automatic test_basic_load();
      logic [DW-1:0] w [8];
      logic [AW-1:0] a [8];
      w = '{8'h93, 8'h16, 8'h27, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00};
      a = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
      start_load(5'd0);
      feed_words(w, 4, 1'b1);
      run_fetches(a, 4);
   endtask

   task automatic test_unloaded();
      logic [AW-1:0] a [8];
      a = '{5'd10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      run_fetches(a, 1);
   endtask

   task automatic test_overrun();
      logic [DW-1:0] w [8];
      logic [AW-1:0] a [8];
      w = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      a = '{5'd30, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      start_load(5'd30);
      feed_words(w, 3, 1'b0);
      run_fetches(a, 3);
   endtask

   task automatic test_load_vs_fetch();
      logic [DW-1:0] w [8];
      logic [AW-1:0] a [8];
      w = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      a = '{5'd12, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      @(negedge clk);
      load_start = 1'b1;
      load_base  = 5'd12;
      fetch_req  = 1'b1;
      fetch_addr = 5'd0;
      #1;
      n_checks++;
      if (fetch_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_fetch_ready: got %b expected 0", fetch_ready);
      end
      @(negedge clk);
      load_start = 1'b0;
      fetch_req  = 1'b0;
      m_in_load  = 1'b1;
      m_ptr      = 5'd12;
      m_err      = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_next: busy=%b instr_valid=%b expected 1 0", busy, instr_valid);
      end
      feed_words(w, 1, 1'b1);
      run_fetches(a, 3);
   endtask

   task automatic test_reset_mid_load();
      logic [DW-1:0] w [8];
      logic [AW-1:0] a [8];
      w = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      start_load(5'd20);
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 8'h11;
      @(negedge clk);
      load_valid = 1'b0;
      rst_n = 1'b0;
      model_clear();
      #1;
      n_checks++;
      if (instr_valid !== 1'b0 || load_err !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE) begin
         n_fail++;
         $display("FAIL midload_reset: valid=%b err=%b busy=%b state=%0d expected 0 0 0 IDLE",
                  instr_valid, load_err, busy, state_dbg);
      end
      @(negedge clk);
      rst_n = 1'b1;
      w = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      a = '{5'd0, 5'd5, 5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      start_load(5'd5);
      feed_words(w, 1, 1'b1);
      run_fetches(a, 3);
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w [8];
      logic [AW-1:0] a [8];
      for (int i = 0; i < 8; i++) w[i] = DW'($urandom_range(0, 255));
      start_load(5'd8);
      feed_words(w, 8, 1'b1);
      for (int i = 0; i < 8; i++) a[i] = AW'($urandom_range(0, DEPTH - 1));
      a[0] = 5'd8;
      a[7] = 5'd15;
      run_fetches(a, 8);
   endtask

   initial begin
      rst_n      = 1'b0;
      load_start = 1'b0;
      load_base  = '0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_clear();
      #2;
      test_reset();
      apply_reset();
      test_reset();
      test_basic_load();
      test_unloaded();
      test_overrun();
      test_load_vs_fetch();
      test_reset_mid_load();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
